// File: rtl/mod12_dec_pkg.sv
// -----------------------------------------------------------------------------
// mod12_dec_pkg
// Shared definitions for the mod-12 count-stream decoder:
//   - evt_code encoding (EVT_NONE..EVT_JUMP)
//   - MOD_MAX, the largest legal counter value
//   - FSM state encoding (IDLE / TRACK)
// -----------------------------------------------------------------------------
package mod12_dec_pkg;

  localparam logic [2:0] EVT_NONE = 3'd0;
  localparam logic [2:0] EVT_UP   = 3'd1;
  localparam logic [2:0] EVT_DOWN = 3'd2;
  localparam logic [2:0] EVT_HOLD = 3'd3;
  localparam logic [2:0] EVT_JUMP = 3'd4;

  localparam logic [3:0] MOD_MAX = 4'd11;

  typedef enum logic {
    IDLE  = 1'b0,   // no reference sample yet
    TRACK = 1'b1    // prev holds a valid reference sample
  } state_e;

endpackage

// File: rtl/mod12_count_decoder_if.sv
// -----------------------------------------------------------------------------
// mod12_count_decoder_if
// Bundles the sample input stream and the decoded event outputs.
//   master : drives clr, cnt_valid, cnt_in; observes the event outputs
//   slave  : the decoder; consumes samples and drives the event outputs
// Signals:
//   clr        synchronous clear of counters and FSM
//   cnt_valid  cnt_in carries a valid sample
//   cnt_in     4-bit counter value
//   evt_valid  event outputs valid this cycle
//   evt_code   NONE/UP/DOWN/HOLD/JUMP
//   wrap_up    up step out of 11 or 15
//   wrap_down  down step 0 -> 11
//   oor        sampled value above 11
//   dir        last step direction (1 up, 0 down)
//   rev_cnt    signed net wrap count (two's complement bits)
//   run_len    consecutive same-direction steps
//   jump_cnt   JUMP event count (zero unless the optional counter is built)
// -----------------------------------------------------------------------------
interface mod12_count_decoder_if #(
  parameter int REV_W = 8,
  parameter int RUN_W = 6
) ();

  logic             clr;
  logic             cnt_valid;
  logic [3:0]       cnt_in;
  logic             evt_valid;
  logic [2:0]       evt_code;
  logic             wrap_up;
  logic             wrap_down;
  logic             oor;
  logic             dir;
  logic [REV_W-1:0] rev_cnt;
  logic [RUN_W-1:0] run_len;
  logic [7:0]       jump_cnt;

  modport master (
    output clr, cnt_valid, cnt_in,
    input  evt_valid, evt_code, wrap_up, wrap_down, oor, dir,
           rev_cnt, run_len, jump_cnt
  );

  modport slave (
    input  clr, cnt_valid, cnt_in,
    output evt_valid, evt_code, wrap_up, wrap_down, oor, dir,
           rev_cnt, run_len, jump_cnt
  );

endinterface

// File: rtl/mod12_step_classify.sv
// -----------------------------------------------------------------------------
// mod12_step_classify
// Purely combinational classification of one step of the mod-12 count stream.
// Ports:
//   prev_i      previous sample
//   cur_i       current sample
//   evt_code_o  HOLD / UP / DOWN / JUMP (first match wins, in that order)
//   wrap_up_o   UP step with prev in {11, 15}
//   wrap_down_o DOWN step with prev == 0
// -----------------------------------------------------------------------------
module mod12_step_classify
  import mod12_dec_pkg::*;
(
  input  logic [3:0] prev_i,
  input  logic [3:0] cur_i,
  output logic [2:0] evt_code_o,
  output logic       wrap_up_o,
  output logic       wrap_down_o
);

  logic [3:0] up_exp;
  logic [3:0] dn_exp;

  // 4-bit arithmetic: out-of-range values step naturally (12->13, 15->0 up;
  // 12->11 down) so a counter recovering from a bad value is still tracked.
  assign up_exp = (prev_i == MOD_MAX) ? 4'd0    : prev_i + 4'd1;
  assign dn_exp = (prev_i == 4'd0)    ? MOD_MAX : prev_i - 4'd1;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave it unassigned (no latch).
  always_comb begin
    evt_code_o  = EVT_JUMP;
    wrap_up_o   = 1'b0;
    wrap_down_o = 1'b0;
    if (cur_i == prev_i) begin
      evt_code_o = EVT_HOLD;
    end else if (cur_i == up_exp) begin
      evt_code_o = EVT_UP;
      wrap_up_o  = (prev_i == MOD_MAX) || (prev_i == 4'd15);
    end else if (cur_i == dn_exp) begin
      evt_code_o  = EVT_DOWN;
      wrap_down_o = (prev_i == 4'd0);
    end
  end

endmodule

// File: rtl/mod12_count_decoder.sv
// -----------------------------------------------------------------------------
// mod12_count_decoder
// Receiver-side monitor for a mod-12 up/down/load counter. Each valid sample
// is classified against the previous one; results appear one cycle later.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mod12_count_decoder_if.slave (sample stream in, events out)
// Parameters:
//   REV_W width of the signed saturating revolution counter
//   RUN_W width of the unsigned saturating run-length counter
// Optional feature:
//   MOD12_DEC_JUMPCNT_EN  when defined, builds a saturating 8-bit JUMP
//                         counter; otherwise jump_cnt is tied to 0.
// -----------------------------------------------------------------------------
module mod12_count_decoder
  import mod12_dec_pkg::*;
#(
  parameter int REV_W = 8,
  parameter int RUN_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  mod12_count_decoder_if.slave  bus
);

  localparam logic signed [REV_W-1:0] REV_MAX = {1'b0, {(REV_W-1){1'b1}}};
  localparam logic signed [REV_W-1:0] REV_MIN = {1'b1, {(REV_W-1){1'b0}}};
  localparam logic signed [REV_W-1:0] REV_ONE = {{(REV_W-1){1'b0}}, 1'b1};
  localparam logic [RUN_W-1:0]        RUN_MAX = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0]        RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [3:0]              prev_q, prev_d;
  logic                    evt_valid_q, evt_valid_d;
  logic [2:0]              evt_code_q, evt_code_d;
  logic                    wrap_up_q, wrap_up_d;
  logic                    wrap_down_q, wrap_down_d;
  logic                    oor_q, oor_d;
  logic                    dir_q, dir_d;
  logic signed [REV_W-1:0] rev_q, rev_d;
  logic [RUN_W-1:0]        run_q, run_d;

  logic [2:0] cls_code;
  logic       cls_wrap_up;
  logic       cls_wrap_down;
  logic       step_up;

  mod12_step_classify u_classify (
    .prev_i      (prev_q),
    .cur_i       (bus.cnt_in),
    .evt_code_o  (cls_code),
    .wrap_up_o   (cls_wrap_up),
    .wrap_down_o (cls_wrap_down)
  );

  assign step_up = (cls_code == EVT_UP);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    evt_valid_d = 1'b0;
    evt_code_d  = EVT_NONE;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;
    oor_d       = 1'b0;
    dir_d       = dir_q;
    rev_d       = rev_q;
    run_d       = run_q;

    if (bus.clr) begin
      // Clear wins over a coincident sample; the sample is dropped.
      state_d = IDLE;
      rev_d   = '0;
      run_d   = '0;
    end else if (bus.cnt_valid) begin
      evt_valid_d = 1'b1;
      oor_d       = (bus.cnt_in > MOD_MAX);
      prev_d      = bus.cnt_in;
      if (state_q == IDLE) begin
        // First sample only establishes the reference; reported as NONE.
        state_d = TRACK;
      end else begin
        evt_code_d  = cls_code;
        wrap_up_d   = cls_wrap_up;
        wrap_down_d = cls_wrap_down;
        if (cls_code == EVT_UP || cls_code == EVT_DOWN) begin
          dir_d = step_up;
          if (step_up != dir_q || run_q == '0) begin
            run_d = RUN_ONE;
          end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_ONE;
          end
        end else begin
          run_d = '0;
        end
        if (cls_wrap_up && rev_q != REV_MAX) begin
          rev_d = rev_q + REV_ONE;
        end else if (cls_wrap_down && rev_q != REV_MIN) begin
          rev_d = rev_q - REV_ONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= 4'd0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= EVT_NONE;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
      oor_q       <= 1'b0;
      dir_q       <= 1'b0;
      rev_q       <= '0;
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
      oor_q       <= oor_d;
      dir_q       <= dir_d;
      rev_q       <= rev_d;
      run_q       <= run_d;
    end
  end

`ifdef MOD12_DEC_JUMPCNT_EN
  logic [7:0] jump_q, jump_d;

  always_comb begin
    jump_d = jump_q;
    if (bus.clr) begin
      jump_d = 8'd0;
    end else if (bus.cnt_valid && state_q == TRACK &&
                 cls_code == EVT_JUMP && jump_q != 8'hFF) begin
      jump_d = jump_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_q <= 8'd0;
    end else begin
      jump_q <= jump_d;
    end
  end

  assign bus.jump_cnt = jump_q;
`else
  assign bus.jump_cnt = 8'd0;
`endif

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.wrap_up   = wrap_up_q;
  assign bus.wrap_down = wrap_down_q;
  assign bus.oor       = oor_q;
  assign bus.dir       = dir_q;
  assign bus.rev_cnt   = rev_q;
  assign bus.run_len   = run_q;

endmodule

// File: tb/tb_mod12_count_decoder.sv
// -----------------------------------------------------------------------------
// tb_mod12_count_decoder
// Self-checking bench for mod12_count_decoder. The stimulus process updates a
// behavioural model and queues the expected event for every accepted sample;
// an independent monitor pops and compares whenever the DUT raises evt_valid.
// -----------------------------------------------------------------------------
module tb_mod12_count_decoder;

  localparam int REV_W = 8;
  localparam int RUN_W = 6;
  localparam int REV_HI = (1 << (REV_W - 1)) - 1;
  localparam int REV_LO = -(1 << (REV_W - 1));
  localparam int RUN_HI = (1 << RUN_W) - 1;

  typedef struct {
    int code;
    bit wu;
    bit wd;
    bit oor;
    bit dir;
    int rev;
    int run;
    int jmp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mod12_count_decoder_if #(.REV_W(REV_W), .RUN_W(RUN_W)) bus ();

  mod12_count_decoder #(.REV_W(REV_W), .RUN_W(RUN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Reference model state
  bit m_idle = 1'b1;
  int m_prev = 0;
  bit m_dir  = 1'b0;
  int m_rev  = 0;
  int m_run  = 0;
  int m_jmp  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int jump_exp(input int j);
`ifdef MOD12_DEC_JUMPCNT_EN
    return (j > 255) ? 255 : j;
`else
    return 0 * j;
`endif
  endfunction

  task automatic model_reset();
    m_idle = 1'b1;
    m_prev = 0;
    m_dir  = 1'b0;
    m_rev  = 0;
    m_run  = 0;
    m_jmp  = 0;
  endtask

  // Drive one cycle of stimulus and advance the model.
  task automatic drive(input bit v, input int c, input bit cl);
    exp_t e;
    int   up, dn;
    @(negedge clk);
    bus.cnt_valid = v;
    bus.cnt_in    = c[3:0];
    bus.clr       = cl;
    if (cl) begin
      m_idle = 1'b1;
      m_rev  = 0;
      m_run  = 0;
      m_jmp  = 0;
    end else if (v) begin
      e.code = 0; e.wu = 0; e.wd = 0;
      e.oor  = (c > 11);
      if (m_idle) begin
        m_idle = 1'b0;
      end else begin
        up = (m_prev == 11) ? 0 : (m_prev + 1) % 16;
        dn = (m_prev == 0) ? 11 : m_prev - 1;
        if (c == m_prev)  e.code = 3;
        else if (c == up) e.code = 1;
        else if (c == dn) e.code = 2;
        else              e.code = 4;
        e.wu = (e.code == 1) && (m_prev == 11 || m_prev == 15);
        e.wd = (e.code == 2) && (m_prev == 0);
        if (e.code == 1 || e.code == 2) begin
          if ((e.code == 1) != m_dir || m_run == 0) m_run = 1;
          else if (m_run < RUN_HI) m_run++;
          m_dir = (e.code == 1);
        end else begin
          m_run = 0;
        end
        if (e.wu && m_rev < REV_HI) m_rev++;
        if (e.wd && m_rev > REV_LO) m_rev--;
        if (e.code == 4) m_jmp++;
      end
      m_prev = c;
      e.dir = m_dir;
      e.rev = m_rev;
      e.run = m_run;
      e.jmp = jump_exp(m_jmp);
      q.push_back(e);
    end
  endtask

  task automatic play(input int vals[$]);
    foreach (vals[i]) drive(1'b1, vals[i], 1'b0);
  endtask

  // Monitor: compares every presented event against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (bus.evt_valid) begin
          if (q.size() == 0) begin
            check("unexpected_evt_valid", 32'(bus.evt_valid), 32'd0);
          end else begin
            e = q.pop_front();
            check("evt_code",  32'(bus.evt_code),  32'(e.code));
            check("wrap_up",   32'(bus.wrap_up),   32'(e.wu));
            check("wrap_down", 32'(bus.wrap_down), 32'(e.wd));
            check("oor",       32'(bus.oor),       32'(e.oor));
            check("dir",       32'(bus.dir),       32'(e.dir));
            check("rev_cnt",   32'(bus.rev_cnt),   32'(e.rev & ((1 << REV_W) - 1)));
            check("run_len",   32'(bus.run_len),   32'(e.run));
            check("jump_cnt",  32'(bus.jump_cnt),  32'(e.jmp));
          end
        end else begin
          check("idle_evt_code",  32'(bus.evt_code),  32'd0);
          check("idle_wrap_up",   32'(bus.wrap_up),   32'd0);
          check("idle_wrap_down", 32'(bus.wrap_down), 32'd0);
        end
      end
    end
  end

  initial begin
    int r, c;
    bit v, cl;
    bus.clr       = 1'b0;
    bus.cnt_valid = 1'b0;
    bus.cnt_in    = 4'd0;

    // Reset state
    #12;
    check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_evt_code",  32'(bus.evt_code),  32'd0);
    check("rst_dir",       32'(bus.dir),       32'd0);
    check("rst_rev_cnt",   32'(bus.rev_cnt),   32'd0);
    check("rst_run_len",   32'(bus.run_len),   32'd0);
    check("rst_jump_cnt",  32'(bus.jump_cnt),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic up steps, wraps in both directions
    play('{3, 4, 5});
    play('{10, 11, 0, 1});
    play('{1, 0, 11});

    // Load-style jumps and out-of-range values
    drive(1'b0, 0, 1'b1);
    play('{2, 9, 9, 14, 15, 0});

    // Out-of-range neighbours and a direction change
    play('{12, 11, 12, 13});
    play('{4, 5, 6, 5, 4});

    // Valid gaps, then clr colliding with a sample
    play('{5});
    drive(1'b0, 9, 1'b0);
    drive(1'b0, 3, 1'b0);
    play('{6});
    drive(1'b1, 7, 1'b1);
    play('{8, 9});

    // Run-length saturation
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 72; i++) drive(1'b1, i % 12, 1'b0);

    // Revolution-count saturation (15 -> 0 is a wrap_up, 0 -> 15 a JUMP)
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 15, 1'b0);
      drive(1'b1, 0, 1'b0);
    end

    // Asynchronous reset in the middle of a sample cycle
    @(negedge clk);
    bus.cnt_valid = 1'b1;
    bus.cnt_in    = 4'd1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("async_rst_rev_cnt",   32'(bus.rev_cnt),   32'd0);
    check("async_rst_run_len",   32'(bus.run_len),   32'd0);
    check("async_rst_dir",       32'(bus.dir),       32'd0);
    check("async_rst_jump_cnt",  32'(bus.jump_cnt),  32'd0);
    q.delete();
    model_reset();
    @(negedge clk);
    bus.cnt_valid = 1'b0;
    rst = 1'b0;
    play('{7, 8});

    // Randomized stream biased toward legal steps
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 59) == 0);
      r  = $urandom_range(0, 9);
      if (r < 4)       c = (m_prev == 11) ? 0 : (m_prev + 1) % 16;
      else if (r < 7)  c = (m_prev == 0) ? 11 : m_prev - 1;
      else if (r == 7) c = m_prev;
      else             c = $urandom_range(0, 15);
      drive(v, c, cl);
    end

    drive(1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_drain", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
